// File: rtl/conv_result_collector_if.sv
// Result-stream bundle between the MAC pipeline and the collector; master drives beats, slave returns results.
// Signal names mirror the collector's port list so both ends read the same.
interface conv_result_collector_if #(
    parameter int LANES = 1
);
    logic                 Valid_i;
    logic                 First_i;
    logic                 Last_i;
    logic [LANES*32-1:0]  Sum_i;
    logic [3:0]           DataBp_i;
    logic [3:0]           WeightBp_i;
    logic [3:0]           ResultBp_i;
    logic                 Halt_o;
    logic [LANES*8-1:0]   Result_o;
    logic                 ResultValid_o;
    logic                 ResultReady_i;
    logic                 ProtoErr_o;

    modport master (
        output Valid_i, First_i, Last_i, Sum_i, DataBp_i, WeightBp_i, ResultBp_i, ResultReady_i,
        input  Halt_o, Result_o, ResultValid_o, ProtoErr_o
    );

    modport slave (
        input  Valid_i, First_i, Last_i, Sum_i, DataBp_i, WeightBp_i, ResultBp_i, ResultReady_i,
        output Halt_o, Result_o, ResultValid_o, ProtoErr_o
    );
endinterface

// File: rtl/conv_result_collector.sv
// Sums First..Last partial-sum groups per lane, realigns with round-half-up and int8 saturation, queues in a FWFT FIFO.
// Latency 2 cycles Last-accept to ResultValid_o; Halt_o freezes upstream while FIFO plus stage cannot take another result.
module conv_result_collector #(
    parameter int LANES = 1,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    conv_result_collector_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, ACC} state_t;

    state_t              state_q;
    logic [39:0]         acc_q   [LANES];
    logic [39:0]         acc_d   [LANES];
    logic signed [71:0]  wide_c  [LANES];
    logic signed [71:0]  shf_c   [LANES];
    logic [LANES*8-1:0]  aligned_d;
    logic [LANES*8-1:0]  stg_q;
    logic                stg_v_q;
    logic [LANES*8-1:0]  mem_q   [DEPTH];
    logic [PW-1:0]       rd_q, wr_q;
    logic [CW-1:0]       cnt_q;
    logic                err_q;

    logic                accept, start, push, pop;
    logic signed [5:0]   sh_c;
    logic [5:0]          amt_r, amt_l, amt_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign accept = bus.Valid_i & ~bus.Halt_o;
    assign start  = bus.First_i | (state_q == IDLE);
    assign push   = stg_v_q;
    assign pop    = (cnt_q != '0) & bus.ResultReady_i;

    assign sh_c  = $signed({2'b00, bus.DataBp_i}) + $signed({2'b00, bus.WeightBp_i})
                 - $signed({2'b00, bus.ResultBp_i});
    assign amt_s = sh_c;
    assign amt_r = sh_c - 6'sd1;
    assign amt_l = -sh_c;

    // 72-bit working width holds a 40-bit total shifted left by up to 15 without wrapping.
    always_comb begin
        aligned_d = '0;
        for (int k = 0; k < LANES; k++) begin
            acc_d[k]  = (start ? 40'd0 : acc_q[k])
                      + {{8{bus.Sum_i[k*32+31]}}, bus.Sum_i[k*32 +: 32]};
            wide_c[k] = $signed({{32{acc_d[k][39]}}, acc_d[k]});
            if (sh_c > 6'sd0)
                shf_c[k] = (wide_c[k] + (72'sd1 <<< amt_r)) >>> amt_s;
            else if (sh_c < 6'sd0)
                shf_c[k] = wide_c[k] <<< amt_l;
            else
                shf_c[k] = wide_c[k];
            if (shf_c[k] > 72'sd127)
                aligned_d[k*8 +: 8] = 8'h7F;
            else if (shf_c[k] < -72'sd128)
                aligned_d[k*8 +: 8] = 8'h80;
            else
                aligned_d[k*8 +: 8] = shf_c[k][7:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            stg_q   <= '0;
            stg_v_q <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (accept) begin
                state_q <= bus.Last_i ? IDLE : ACC;
                for (int k = 0; k < LANES; k++) acc_q[k] <= acc_d[k];
                if ((state_q == IDLE && !bus.First_i) || (state_q == ACC && bus.First_i))
                    err_q <= 1'b1;
            end
            // A staged result always drains next edge; Halt_o reserved the FIFO slot.
            if (accept && bus.Last_i) begin
                stg_q   <= aligned_d;
                stg_v_q <= 1'b1;
            end else begin
                stg_v_q <= 1'b0;
            end
            if (push) begin
                mem_q[wr_q] <= stg_q;
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop)
                rd_q <= ptr_inc(rd_q);
            if (push && !pop)
                cnt_q <= cnt_q + 1'b1;
            else if (!push && pop)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    assign bus.Halt_o        = (int'(cnt_q) + int'(stg_v_q)) >= DEPTH;
    assign bus.ResultValid_o = (cnt_q != '0);
    assign bus.Result_o      = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign bus.ProtoErr_o    = err_q;
endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector: vector table of groups plus hand sequences
// for backpressure, framing errors, throughput and asynchronous reset.
module tb_conv_result_collector;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    conv_result_collector_if #(.LANES(1)) bus();
    conv_result_collector #(.LANES(1), .DEPTH(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;
    int halt_cnt = 0;
    logic [7:0] got_q[$];

    // Pops happen on the next rising edge, so the negedge view is what leaves the FIFO.
    always @(negedge clk) begin
        if (bus.ResultValid_o && bus.ResultReady_i) got_q.push_back(bus.Result_o);
        if (bus.Halt_o) halt_cnt++;
    end

    typedef struct {
        string      name;
        int         nb;
        int         s0, s1, s2;
        logic [3:0] d, w, r;
        int         exp;
    } vec_t;

    vec_t tv[13];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_bp(input logic [3:0] d, input logic [3:0] w, input logic [3:0] r);
        bus.DataBp_i = d; bus.WeightBp_i = w; bus.ResultBp_i = r;
    endtask

    task automatic send(input bit f, input bit l, input int s);
        int n;
        bus.First_i = f; bus.Last_i = l; bus.Sum_i = 32'(s); bus.Valid_i = 1'b1;
        n = 0;
        while (bus.Halt_o && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            n_chk++;
            $display("FAIL send_timeout: Halt_o still high after %0d cycles", n);
        end
        @(posedge clk); #1;
        bus.Valid_i = 1'b0; bus.First_i = 1'b0; bus.Last_i = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic int sres();
        return int'($signed(bus.Result_o));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int h0;
        tv[0]  = '{"grp3",     3,   100,   200,  300, 4'd4, 4'd4, 4'd4,   38};
        tv[1]  = '{"neg_half", 1,  -600,     0,    0, 4'd4, 4'd4, 4'd4,  -37};
        tv[2]  = '{"sat_pos",  3,  2000,  2000, 1000, 4'd4, 4'd4, 4'd4,  127};
        tv[3]  = '{"sat_neg",  3, -2000, -2000,-1000, 4'd4, 4'd4, 4'd4, -128};
        tv[4]  = '{"lsh",      1,    10,     0,    0, 4'd1, 4'd1, 4'd4,   40};
        tv[5]  = '{"lsh_sat",  1,    40,     0,    0, 4'd1, 4'd1, 4'd4,  127};
        tv[6]  = '{"half_up",  1,     8,     0,    0, 4'd4, 4'd4, 4'd4,    1};
        tv[7]  = '{"nhalf_up", 1,    -8,     0,    0, 4'd4, 4'd4, 4'd4,    0};
        tv[8]  = '{"nbelow",   1,    -9,     0,    0, 4'd4, 4'd4, 4'd4,   -1};
        tv[9]  = '{"sh30",     1, 32'h7FFFFFFF, 0, 0, 4'd15, 4'd15, 4'd0,  2};
        tv[10] = '{"lsh15",    1,     3,     0,    0, 4'd0, 4'd0, 4'd15, 127};
        tv[11] = '{"nlsh15",   1,    -3,     0,    0, 4'd0, 4'd0, 4'd15,-128};
        tv[12] = '{"sh0",      2,   100,   -30,    0, 4'd5, 4'd0, 4'd5,   70};

        bus.Valid_i = 1'b0; bus.First_i = 1'b0; bus.Last_i = 1'b0; bus.Sum_i = '0;
        bus.ResultReady_i = 1'b1;
        set_bp(4'd0, 4'd0, 4'd0);

        #12;
        check("rst_halt", int'(bus.Halt_o), 0);
        check("rst_rv", int'(bus.ResultValid_o), 0);
        check("rst_res", int'(bus.Result_o), 0);
        check("rst_err", int'(bus.ProtoErr_o), 0);
        rstn = 1'b1;
        wait_edges(1);

        for (int i = 0; i < 13; i++) begin
            set_bp(tv[i].d, tv[i].w, tv[i].r);
            send(1'b1, tv[i].nb == 1, tv[i].s0);
            if (tv[i].nb >= 2) send(1'b0, tv[i].nb == 2, tv[i].s1);
            if (tv[i].nb == 3) send(1'b0, 1'b1, tv[i].s2);
            check({tv[i].name, "_rv_early"}, int'(bus.ResultValid_o), 0);
            wait_edges(1);
            check({tv[i].name, "_rv"}, int'(bus.ResultValid_o), 1);
            check({tv[i].name, "_res"}, sres(), tv[i].exp);
        end
        wait_edges(1);

        // implicit First from IDLE
        check("err_clean", int'(bus.ProtoErr_o), 0);
        set_bp(4'd0, 4'd0, 4'd0);
        send(1'b0, 1'b1, 50);
        check("err_implicit", int'(bus.ProtoErr_o), 1);
        wait_edges(1);
        check("implicit_res", sres(), 50);

        // First in ACC restarts the group
        #1 rstn = 1'b0;
        #2 rstn = 1'b1;
        check("err_after_rst", int'(bus.ProtoErr_o), 0);
        wait_edges(1);
        send(1'b1, 1'b0, 1000);
        send(1'b1, 1'b0, 5);
        check("err_restart", int'(bus.ProtoErr_o), 1);
        send(1'b0, 1'b1, 6);
        wait_edges(1);
        check("restart_res", sres(), 11);
        wait_edges(1);

        // back-to-back single-beat groups with ready held high
        set_bp(4'd4, 4'd4, 4'd4);
        base = got_q.size();
        h0 = halt_cnt;
        for (int k = 1; k <= 6; k++) send(1'b1, 1'b1, 16 * k);
        wait_edges(4);
        check("tput_no_halt", halt_cnt - h0, 0);
        check("tput_count", got_q.size() - base, 6);
        for (int k = 1; k <= 6; k++)
            if (base + k - 1 < got_q.size())
                check("tput_order", int'($signed(got_q[base + k - 1])), k);

        // backpressure: FIFO fills, fifth beat is held
        bus.ResultReady_i = 1'b0;
        base = got_q.size();
        for (int k = 1; k <= 4; k++) begin
            send(1'b1, 1'b1, 16 * k);
            check("bp_halt", int'(bus.Halt_o), (k == 4) ? 1 : 0);
        end
        bus.First_i = 1'b1; bus.Last_i = 1'b1; bus.Sum_i = 32'd80; bus.Valid_i = 1'b1;
        wait_edges(3);
        check("bp_halt_hold", int'(bus.Halt_o), 1);
        check("bp_head", sres(), 1);
        bus.ResultReady_i = 1'b1;
        wait_edges(1);
        check("bp_release", int'(bus.Halt_o), 0);
        wait_edges(1);
        bus.Valid_i = 1'b0; bus.First_i = 1'b0; bus.Last_i = 1'b0;
        wait_edges(8);
        check("bp_count", got_q.size() - base, 5);
        for (int k = 1; k <= 5; k++)
            if (base + k - 1 < got_q.size())
                check("bp_order", int'($signed(got_q[base + k - 1])), k);

        // reset with an open group and two queued results
        bus.ResultReady_i = 1'b0;
        send(1'b1, 1'b1, 16);
        send(1'b1, 1'b1, 32);
        wait_edges(2);
        send(1'b1, 1'b0, 100);
        send(1'b0, 1'b0, 200);
        check("pre_rst_rv", int'(bus.ResultValid_o), 1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_halt", int'(bus.Halt_o), 0);
        check("mid_rst_rv", int'(bus.ResultValid_o), 0);
        check("mid_rst_res", int'(bus.Result_o), 0);
        check("mid_rst_err", int'(bus.ProtoErr_o), 0);
        rstn = 1'b1;
        wait_edges(1);
        bus.ResultReady_i = 1'b1;
        set_bp(4'd0, 4'd0, 4'd0);
        base = got_q.size();
        send(1'b1, 1'b1, 7);
        wait_edges(4);
        check("post_rst_count", got_q.size() - base, 1);
        if (base < got_q.size())
            check("post_rst_res", int'($signed(got_q[base])), 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv_result_collector.md
# conv_result_collector

Consumer end of the multiply-accumulate pipeline's First/Valid/Last result stream. It sums 32-bit signed partial sums across a First..Last group in per-lane 40-bit accumulators, then realigns each total from the operand binary point to the result binary point with round-half-up and signed 8-bit saturation. Completed results are queued in a small FIFO behind a valid/ready output. While that FIFO cannot absorb another result, `Halt_o` is driven back to freeze the upstream pipeline.

## Interface
- `LANES`, default 1: number of parallel 32-bit partial-sum lanes.
- `DEPTH`, default 4: result FIFO entries (≥2).
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `Valid_i` input 1: partial-sum beat present.
- `First_i` input 1: beat opens a group.
- `Last_i` input 1: beat closes a group. May coincide with `First_i`.
- `Sum_i` input LANES*32: signed two's-complement partial sums; lane k is `[k*32+31:k*32]`.
- `DataBp_i`, `WeightBp_i`, `ResultBp_i` input 4 each: binary-point positions, unsigned.
- `Halt_o` output 1: upstream freeze; drives the producer's halt input.
- `Result_o` output LANES*8: signed saturated results, lane k is `[k*8+7:k*8]`.
- `ResultValid_o` output 1: FIFO head valid.
- `ResultReady_i` input 1: downstream accepts the head.
- `ProtoErr_o` output 1: sticky framing-error flag.

## Operation
- Accept: a beat is consumed only when `Valid_i & ~Halt_o`. While `Halt_o` is high, the held upstream beat is ignored, so it is never double-counted.
- State machine `IDLE` / `ACC`. Reset enters `IDLE`.
  - Any accepted beat with `Last_i` → `IDLE`.
  - Any accepted beat without `Last_i` → `ACC`.
- Accumulator update on an accepted beat:
  - `acc ← (start ? 0 : acc) + sext40(Sum_i lane)`.
  - `start` is `First_i`, or the FSM being in `IDLE`.
  - 40-bit overflow wraps.
- Framing errors, each of which sets `ProtoErr_o`; it stays high until reset:
  - Beat accepted in `IDLE` without `First_i`: treated as an implicit First.
  - `First_i` accepted in `ACC`: the open group is discarded and restarted.
- Alignment, applied combinationally on the Last beat to `total = acc_next`:
  - Shift amount is the 6-bit signed value `sh = DataBp_i + WeightBp_i − ResultBp_i`. Binary points are sampled on the Last beat and must be stable per group.
  - `sh > 0`: `(total + 2^(sh−1)) >>> sh` (arithmetic shift, round half up).
  - `sh = 0`: `total` unchanged.
  - `sh < 0`: `total << −sh`, computed at full width with no wrap before saturation.
  - Saturate to [−128, 127] per lane.
- Stage register: the aligned vector is loaded on the Last accept with `stg_v = 1`. On the next cycle it pushes into the FIFO and `stg_v` clears, unless another Last is accepted in that cycle.
- FIFO: `DEPTH` entries, first-word-fall-through. Pop on `ResultValid_o & ResultReady_i`. Simultaneous push and pop is allowed at any occupancy.
- Halt rule: `Halt_o = (count + stg_v ≥ DEPTH)`, combinational from registered state. This guarantees a stage push never meets a full FIFO, and no result is ever dropped.

## Timing
- Reset values:
  - `Halt_o` = 0, `ResultValid_o` = 0, `Result_o` = 0, `ProtoErr_o` = 0.
  - FSM in `IDLE`, accumulators = 0, `stg_v` = 0, FIFO empty.
- Latency: a Last beat accepted at edge t loads the stage at t. The result is pushed at t+1, and `ResultValid_o` is high in the cycle after edge t+1, i.e. 2 cycles.
- Throughput: one single-beat group per cycle while `ResultReady_i` is held high. `Halt_o` never asserts in that case.
- Halt release: a pop at edge t lowers `Halt_o` in the cycle after t. The held beat is then consumed on the following edge.
- Reset asserted mid-group or mid-queue: all state, including queued results, is discarded immediately and asynchronously.

## Test plan
- Normal group: LANES=1, Bp 4/4/4 (sh=4), beats 100 (First), 200, 300 (Last), ready=1 → `Result_o` = 38, with `ResultValid_o` high 2 cycles after the Last accept.
- Negative value and saturation:
  - Single-beat group −600 at sh=4 → 0xDB (−37), showing half rounds up.
  - Group totalling 5000 at sh=4 → 127.
  - Group totalling −5000 at sh=4 → −128.
- Left shift: Bp 1/1/4 (sh=−2), single beat 10 → 40. Single beat 40 → 127 (saturated).
- Backpressure: DEPTH=4, `ResultReady_i`=0, five consecutive single-beat groups 16, 32, 48, 64, 80 at sh=4:
  - `Halt_o` rises after the fourth accept; the fifth beat is held, not counted.
  - Raising ready drains results 1, 2, 3, 4, 5 in order, with none lost or duplicated.
- Framing errors:
  - Beat 50 without First in `IDLE` (implicit First) → `ProtoErr_o` = 1; at sh=0 the group result includes 50.
  - A First arriving mid-group → the earlier partial is discarded, and the result equals the new group's sum only.
- Reset mid-group: accumulate 100 and 200, assert `rstn` low with 2 results queued → all outputs return to reset values. A subsequent group 7 (First+Last, sh=0) yields exactly 7.
